// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: state encoding, default
// rates, and the tick-counter width rule.
package mux_scan_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int CLK_FREQ_HZ      = 50_000_000;
  localparam int DEFAULT_TICK_DIV = 25_000_000;

  // Counter must hold 0..tick_div-1; a 1-bit counter is the floor.
  function automatic int tick_cnt_w(input int tick_div);
    return ($clog2(tick_div) < 1) ? 1 : $clog2(tick_div);
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Free-running modulo-TICK_DIV counter; Tick marks the last cycle of each
// period so the caller can advance on the following edge.
module rate_divider
  import mux_scan_sequencer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Tick
);

  localparam int CNT_W = tick_cnt_w(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (Clear) begin
      count <= '0;
    end else if (Enable) begin
      count <= Tick ? '0 : count + 1'b1;
    end
  end

  assign Tick = (count == LAST);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives a bit-select mux: latches a pattern on Start and steps the select
// through every bit at the rate_divider pace, bit 0 first.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int NUM_BITS = 7,
  parameter int SEL_W    = 3,
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Abort,
  input  logic [NUM_BITS-1:0] Pattern,
  output logic [NUM_BITS-1:0] Data,
  output logic [SEL_W-1:0]    MuxSelect,
  output logic                BitStrobe,
  output logic                Busy,
  output logic                Done
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_BITS - 1);

  state_e              state, state_d;
  logic [NUM_BITS-1:0] data_d;
  logic [SEL_W-1:0]    sel_d;
  logic                strobe_d, busy_d, done_d;
  logic                tick;

  // The divider idles at zero outside SCAN, so every scan starts a fresh period.
  rate_divider #(.TICK_DIV(TICK_DIV)) u_rate_divider (
    .Clock (Clock),
    .Reset (Reset),
    .Clear ((state != SCAN) || Abort),
    .Enable(state == SCAN),
    .Tick  (tick)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      Data      <= '0;
      MuxSelect <= '0;
      BitStrobe <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= state_d;
      Data      <= data_d;
      MuxSelect <= sel_d;
      BitStrobe <= strobe_d;
      Busy      <= busy_d;
      Done      <= done_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d  = state;
    data_d   = Data;
    sel_d    = MuxSelect;
    strobe_d = 1'b0;
    busy_d   = Busy;
    done_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          data_d   = Pattern;
          sel_d    = '0;
          busy_d   = 1'b1;
          strobe_d = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        // Abort outranks a same-cycle period wrap, so it never raises Done.
        if (Abort) begin
          sel_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (tick) begin
          if (MuxSelect == LAST_SEL) begin
            sel_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            sel_d    = MuxSelect + 1'b1;
            strobe_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a TICK_DIV=4 and a TICK_DIV=1 instance share
// stimulus and are compared every cycle against a scan-schedule model.
module tb_mux_scan_sequencer;

  localparam int NB = 7;

  logic          Clock, Reset, Start, Abort;
  logic [NB-1:0] Pattern;
  logic [NB-1:0] data4, data1;
  logic [2:0]    sel4, sel1;
  logic          strobe4, strobe1, busy4, busy1, done4, done1;

  int errors = 0;
  int checks = 0;

  mux_scan_sequencer #(.NUM_BITS(NB), .SEL_W(3), .TICK_DIV(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
    .Pattern(Pattern), .Data(data4), .MuxSelect(sel4),
    .BitStrobe(strobe4), .Busy(busy4), .Done(done4)
  );

  mux_scan_sequencer #(.NUM_BITS(NB), .SEL_W(3), .TICK_DIV(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
    .Pattern(Pattern), .Data(data1), .MuxSelect(sel1),
    .BitStrobe(strobe1), .Busy(busy1), .Done(done1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Model: a scan is "k cycles since the accepting edge"; bit index = k/T.
  typedef struct {
    bit            active;
    int            k;
    logic [NB-1:0] data;
    bit            done;
  } mdl_t;

  mdl_t m4, m1;

  function automatic mdl_t mstep(mdl_t m, bit st, bit ab, logic [NB-1:0] p, int t);
    mdl_t r = m;
    r.done = 1'b0;
    if (!m.active) begin
      if (st) begin
        r.active = 1'b1;
        r.k      = 0;
        r.data   = p;
      end
    end else if (ab) begin
      r.active = 1'b0;
    end else begin
      r.k = m.k + 1;
      if (r.k == NB * t) begin
        r.active = 1'b0;
        r.done   = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic mdl_t mreset();
    mdl_t r;
    r.active = 1'b0;
    r.k      = 0;
    r.data   = '0;
    r.done   = 1'b0;
    return r;
  endfunction

  function automatic int exp_sel(mdl_t m, int t);
    return m.active ? m.k / t : 0;
  endfunction

  function automatic bit exp_strobe(mdl_t m, int t);
    return m.active && (m.k % t == 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    check("d4_busy",   32'(busy4),   32'(m4.active));
    check("d4_sel",    32'(sel4),    32'(exp_sel(m4, 4)));
    check("d4_strobe", 32'(strobe4), 32'(exp_strobe(m4, 4)));
    check("d4_done",   32'(done4),   32'(m4.done));
    check("d4_data",   32'(data4),   32'(m4.data));
    check("d1_busy",   32'(busy1),   32'(m1.active));
    check("d1_sel",    32'(sel1),    32'(exp_sel(m1, 1)));
    check("d1_strobe", 32'(strobe1), 32'(exp_strobe(m1, 1)));
    check("d1_done",   32'(done1),   32'(m1.done));
    check("d1_data",   32'(data1),   32'(m1.data));
  endtask

  task automatic cyc();
    m4 = mstep(m4, Start, Abort, Pattern, 4);
    m1 = mstep(m1, Start, Abort, Pattern, 1);
    @(posedge Clock);
    #1;
    check_models();
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #3;
    Reset = 1'b1;
    #1;
    check("rst_d4_outs", {data4, sel4, strobe4, busy4, done4}, 32'd0);
    check("rst_d1_outs", {data1, sel1, strobe1, busy1, done1}, 32'd0);
    m4 = mreset();
    m1 = mreset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check_models();
  endtask

  typedef struct {
    bit            start;
    bit            abort;
    logic [NB-1:0] pat;
    bit            busy;
    logic [2:0]    sel;
    bit            strobe;
    bit            done;
    logic [NB-1:0] data;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int busy_cnt, strobe_cnt, done_cnt;
    logic [NB-1:0] got;
    bit found;

    vecs[0]  = '{1, 0, 7'h53, 1, 0, 1, 0, 7'h53};
    vecs[1]  = '{0, 0, 7'h00, 1, 0, 0, 0, 7'h53};
    vecs[2]  = '{0, 0, 7'h00, 1, 0, 0, 0, 7'h53};
    vecs[3]  = '{0, 0, 7'h00, 1, 0, 0, 0, 7'h53};
    vecs[4]  = '{0, 0, 7'h00, 1, 1, 1, 0, 7'h53};
    vecs[5]  = '{1, 0, 7'h00, 1, 1, 0, 0, 7'h53};
    vecs[6]  = '{0, 0, 7'h00, 1, 1, 0, 0, 7'h53};
    vecs[7]  = '{0, 0, 7'h00, 1, 1, 0, 0, 7'h53};
    vecs[8]  = '{0, 0, 7'h00, 1, 2, 1, 0, 7'h53};
    vecs[9]  = '{0, 1, 7'h00, 0, 0, 0, 0, 7'h53};
    vecs[10] = '{0, 0, 7'h00, 0, 0, 0, 0, 7'h53};

    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Pattern = '0;
    m4 = mreset();
    m1 = mreset();
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    check_models();

    // Idle with Start low: everything stays at zero.
    repeat (10) cyc();

    // Directed vectors: start, ignored Start/Pattern, abort at first sel=2 cycle.
    for (int i = 0; i < 11; i++) begin
      Start = vecs[i].start; Abort = vecs[i].abort; Pattern = vecs[i].pat;
      cyc();
      check($sformatf("vec%0d_busy", i),   32'(busy4),   32'(vecs[i].busy));
      check($sformatf("vec%0d_sel", i),    32'(sel4),    32'(vecs[i].sel));
      check($sformatf("vec%0d_strobe", i), 32'(strobe4), 32'(vecs[i].strobe));
      check($sformatf("vec%0d_done", i),   32'(done4),   32'(vecs[i].done));
      check($sformatf("vec%0d_data", i),   32'(data4),   32'(vecs[i].data));
    end
    Start = 1'b0; Abort = 1'b0;

    async_reset();

    // Full scan; the mux output sampled at each strobe must replay the pattern.
    Pattern = 7'b1010011; Start = 1'b1;
    cyc();
    Start = 1'b0;
    busy_cnt = 32'(busy4); strobe_cnt = 0; done_cnt = 0; got = '0;
    if (strobe4) begin got[0] = data4[sel4]; strobe_cnt = 1; end
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin Start = 1'b1; Pattern = 7'b0000000; end
      if (i == 6) Start = 1'b0;
      cyc();
      busy_cnt += 32'(busy4);
      done_cnt += 32'(done4);
      if (strobe4) begin
        if (strobe_cnt < NB) got[strobe_cnt] = data4[sel4];
        strobe_cnt++;
      end
    end
    check("scan_busy_cycles", busy_cnt, 28);
    check("scan_strobes", strobe_cnt, 7);
    check("scan_dones", done_cnt, 1);
    check("scan_mux_bits", 32'(got), 32'(7'b1010011));
    check("scan_data_kept", 32'(data4), 32'(7'b1010011));

    // Abort at the first cycle of select 2; Done must never follow.
    Start = 1'b1; Pattern = 7'h35;
    cyc();
    Start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (sel4 == 3'd2 && strobe4) found = 1'b1;
    end
    check("abort_reached_sel2", 32'(found), 1);
    Abort = 1'b1;
    cyc();
    Abort = 1'b0;
    check("abort_busy", 32'(busy4), 0);
    check("abort_sel", 32'(sel4), 0);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      done_cnt += 32'(done4);
    end
    check("abort_no_done", done_cnt, 0);

    // Abort on the edge that would otherwise complete the scan.
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    repeat (27) cyc();
    check("final_sel6", 32'(sel4), 6);
    Abort = 1'b1;
    cyc();
    Abort = 1'b0;
    check("final_abort_done", 32'(done4), 0);
    check("final_abort_busy", 32'(busy4), 0);
    cyc();
    check("final_abort_done_after", 32'(done4), 0);

    // Reset in the middle of select 3, then a clean scan.
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    repeat (12) cyc();
    check("midrst_sel3", 32'(sel4), 3);
    async_reset();
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    busy_cnt = 32'(busy4);
    for (int i = 0; i < 35; i++) begin
      cyc();
      busy_cnt += 32'(busy4);
    end
    check("midrst_rescan_busy", busy_cnt, 28);

    // Start held high: Done, one idle cycle, then a recapture of Pattern.
    Start = 1'b1; Pattern = 7'h11;
    cyc();
    Pattern = 7'h2A;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (done4) found = 1'b1;
    end
    check("b2b_done_seen", 32'(found), 1);
    check("b2b_idle_busy", 32'(busy4), 0);
    cyc();
    check("b2b_restart_busy", 32'(busy4), 1);
    check("b2b_restart_strobe", 32'(strobe4), 1);
    check("b2b_restart_data", 32'(data4), 32'h2A);
    Start = 1'b0;
    repeat (40) cyc();

    // TICK_DIV=1: one select per cycle, strobe high for the whole scan.
    Start = 1'b1; Pattern = 7'h5C;
    cyc();
    Start = 1'b0;
    busy_cnt = 32'(busy1); strobe_cnt = 32'(strobe1);
    check("t1_sel_0", 32'(sel1), 0);
    for (int i = 1; i < 10; i++) begin
      cyc();
      if (i < NB) check($sformatf("t1_sel_%0d", i), 32'(sel1), i);
      busy_cnt += 32'(busy1);
      strobe_cnt += 32'(strobe1);
    end
    check("t1_busy_cycles", busy_cnt, 7);
    check("t1_strobe_cycles", strobe_cnt, 7);
    repeat (30) cyc();

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      Start   = ($urandom_range(3) == 0);
      Abort   = ($urandom_range(15) == 0);
      Pattern = NB'($urandom);
      cyc();
    end
    Start = 1'b0; Abort = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
